mfp_ahb_simple_master: RTL and testbench

Single-transfer AHB-Lite initiator that turns a valid/ready command stream into one SINGLE/NONSEQ bus transfer per command, with wait-state handling, error-response capture, byte-lane steering and a watchdog timeout. It sits in front of the AHB-Lite matrix as a secondary master for debug/bridge logic such as UART-to-bus and test sequencers. It drives the same slave population as the CPU, including the GPIO and port slaves.

---
 rtl/mfp_ahb_simple_master_pkg.sv | 28 ++
 rtl/mfp_ahb_lane_steer.sv | 34 +++
 rtl/mfp_ahb_simple_master.sv | 203 ++++++++++++++++++++
 tb/tb_mfp_ahb_simple_master.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_simple_master_pkg.sv
// Shared AHB-Lite encodings and helpers for the simple bus master and its
// lane-steering block.
//   HTRANS_*  : transfer type codes (only IDLE and NONSEQ are issued)
//   HBURST_*  : burst code (SINGLE only)
//   SIZE_*    : command / HSIZE size codes (byte, half, word)
//   cmd_misaligned() : 1 when a size/address pair cannot go on the bus
package mfp_ahb_simple_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size 3 (doubleword) is not supported on this 32-bit bus.
  function automatic logic cmd_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr);
    case (size)
      SIZE_BYTE: cmd_misaligned = 1'b0;
      SIZE_HALF: cmd_misaligned = addr[0];
      SIZE_WORD: cmd_misaligned = |addr;
      default:   cmd_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mfp_ahb_lane_steer.sv
// Little-endian byte-lane steering for a 32-bit AHB-Lite master.
//   size_i  : transfer size code (byte/half/word)
//   addr_i  : low address bits of the transfer
//   wdata_i : right-justified write data   -> wdata_o : lane-replicated HWDATA
//   rdata_i : raw HRDATA                   -> rdata_o : right-justified, zero-extended
// Purely combinational so other masters can reuse it.
module mfp_ahb_lane_steer
  import mfp_ahb_simple_master_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    case (size_i)
      SIZE_BYTE: wdata_o = {4{wdata_i[7:0]}};
      SIZE_HALF: wdata_o = {2{wdata_i[15:0]}};
      default:   wdata_o = wdata_i;
    endcase
  end

  always_comb begin
    case (size_i)
      SIZE_BYTE: rdata_o = {24'h0, rdata_i[{addr_i, 3'b000} +: 8]};
      SIZE_HALF: rdata_o = {16'h0, rdata_i[{addr_i[1], 4'b0000} +: 16]};
      default:   rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mfp_ahb_simple_master.sv
// Single-transfer AHB-Lite initiator. Each accepted command becomes one
// SINGLE/NONSEQ transfer; the result is returned on a held response channel.
//   HCLK/HRESETn        : bus clock, async active-low reset
//   H* outputs          : registered AHB-Lite address/control/write data
//   HRDATA/HREADY/HRESP : slave response
//   cmd_*               : valid/ready command stream (write, addr, size, wdata)
//   rsp_*               : valid/ready response (rdata, error, timeout)
// Misaligned commands skip the bus and answer with rsp_error. A watchdog
// abandons a transfer after TIMEOUT_CYCLES consecutive wait cycles (0 = off).
module mfp_ahb_simple_master
  import mfp_ahb_simple_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;

  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, wraw_q, wraw_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d, cmd_ready_q, cmd_ready_d;
  logic [31:0] cap_rdata_q, cap_rdata_d;
  logic        cap_err_q, cap_err_d, cap_to_q, cap_to_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic [31:0] steer_wdata, steer_rdata;
  logic        accept, cmd_bad, wd_hit;

  assign accept  = cmd_valid && cmd_ready_q;
  assign cmd_bad = cmd_misaligned(cmd_size, cmd_addr[1:0]);
  // Fires on the wait cycle that would bring the count to the limit.
  assign wd_hit  = (WD_LIMIT != 32'd0) && !HREADY && (wd_cnt_q == WD_LIMIT - 32'd1);

  // Steering works on the latched transfer, never on live bus inputs.
  mfp_ahb_lane_steer u_steer (
    .size_i  (hsize_q[1:0]),
    .addr_i  (haddr_q[1:0]),
    .wdata_i (wraw_q),
    .wdata_o (steer_wdata),
    .rdata_i (cap_rdata_q),
    .rdata_o (steer_rdata)
  );

  // State register plus all registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      haddr_q       <= '0;
      hwdata_q      <= '0;
      wraw_q        <= '0;
      hsize_q       <= 3'd2;
      htrans_q      <= HTRANS_IDLE;
      hwrite_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      cap_rdata_q   <= '0;
      cap_err_q     <= 1'b0;
      cap_to_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      haddr_q       <= haddr_d;
      hwdata_q      <= hwdata_d;
      wraw_q        <= wraw_d;
      hsize_q       <= hsize_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      cmd_ready_q   <= cmd_ready_d;
      cap_rdata_q   <= cap_rdata_d;
      cap_err_q     <= cap_err_d;
      cap_to_q      <= cap_to_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = cmd_bad ? ST_RESP : ST_ADDR;
      ST_ADDR: if (HREADY) state_d = ST_DATA;
               else if (wd_hit) state_d = ST_RESP;
      ST_DATA: if (HREADY || wd_hit) state_d = ST_RESP;
      ST_RESP: if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; every bus output is derived from state_d
  // so nothing reaches a pin combinationally from the slave.
  always_comb begin
    haddr_d       = haddr_q;
    hsize_d       = hsize_q;
    hwrite_d      = hwrite_q;
    wraw_d        = wraw_q;
    hwdata_d      = hwdata_q;
    htrans_d      = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    cmd_ready_d   = (state_d == ST_IDLE);
    cap_rdata_d   = cap_rdata_q;
    cap_err_d     = cap_err_q;
    cap_to_d      = cap_to_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;

    if (state_d != state_q)
      wd_cnt_d = '0;
    else if ((state_q == ST_ADDR || state_q == ST_DATA) && !HREADY)
      wd_cnt_d = wd_cnt_q + 32'd1;
    else
      wd_cnt_d = wd_cnt_q;

    if (accept) begin
      // A rejected command leaves the bus registers untouched.
      if (!cmd_bad) begin
        haddr_d  = cmd_addr;
        hsize_d  = {1'b0, cmd_size};
        hwrite_d = cmd_write;
        wraw_d   = cmd_wdata;
      end
      cap_err_d   = cmd_bad;
      cap_to_d    = 1'b0;
      cap_rdata_d = '0;
    end

    if (state_q == ST_ADDR && HREADY)
      hwdata_d = steer_wdata;

    if (state_q == ST_DATA && HREADY) begin
      cap_rdata_d = HRDATA;
      cap_err_d   = HRESP;
    end

    if (wd_hit && (state_q == ST_ADDR || state_q == ST_DATA)) begin
      cap_err_d = 1'b1;
      cap_to_d  = 1'b1;
    end

    // Response fields load once on the first RESP cycle and then hold.
    if (state_q == ST_RESP && !rsp_valid_q) begin
      rsp_valid_d   = 1'b1;
      rsp_error_d   = cap_err_q;
      rsp_timeout_d = cap_to_q;
      rsp_rdata_d   = (hwrite_q || cap_err_q) ? 32'h0 : steer_rdata;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign HADDR       = haddr_q;
  assign HBURST      = HBURST_SINGLE;
  assign HMASTLOCK   = 1'b0;
  assign HPROT       = HPROT_VAL;
  assign HSIZE       = hsize_q;
  assign HTRANS      = htrans_q;
  assign HWDATA      = hwdata_q;
  assign HWRITE      = hwrite_q;
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_mfp_ahb_simple_master.sv
// Directed bench for mfp_ahb_simple_master with a hand-driven slave.
module tb_mfp_ahb_simple_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA, cmd_addr, cmd_wdata, rsp_rdata;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS, cmd_size;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_simple_master #(.TIMEOUT_CYCLES(8), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Offer a command; returns 1 unit after the accept edge (edge 0).
  task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'h0);
    chk({tag, "_haddr"}, HADDR, 32'h0);
    chk({tag, "_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    chk({tag, "_hsize"}, 32'(HSIZE), 32'h2);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    chk({tag, "_rsp"}, {rsp_rdata[29:0], rsp_valid, rsp_error | rsp_timeout},
        32'h0);
  endtask

  initial begin
    int stable;
    HRESETn = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; rsp_ready = 1'b0;
    #12;
    chk_reset_vals("rst");
    chk("rst_const", {25'h0, HBURST, HMASTLOCK, HPROT}, {25'h0, 3'b000, 1'b0, 4'b0011});
    @(negedge HCLK); HRESETn = 1'b1;
    tick();

    // Word write, zero wait.
    send(1'b1, 32'hffff0000, 2'd2, 32'h00001234);
    chk("wr_nonseq", 32'(HTRANS), 32'h2);
    chk("wr_haddr", HADDR, 32'hffff0000);
    chk("wr_ctrl", {29'h0, HWRITE, cmd_ready, 1'b0}, {29'h0, 1'b1, 1'b0, 1'b0});
    tick();
    chk("wr_hwdata", HWDATA, 32'h00001234);
    chk("wr_htrans_idle", 32'(HTRANS), 32'h0);
    tick();
    chk("wr_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("wr_rsp", {29'h0, rsp_valid, rsp_error, rsp_timeout}, 32'h4);
    take_rsp();
    chk("wr_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);

    // Byte read at 3 with two wait states in DATA.
    send(1'b0, 32'h00000003, 2'd0, 32'h0);
    chk("rdb_nonseq", 32'(HTRANS), 32'h2);
    tick();
    HREADY = 1'b0;
    tick();
    tick();
    HREADY = 1'b1; HRDATA = 32'hAABBCCDD;
    tick();
    HRDATA = 32'h0;
    chk("rdb_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("rdb_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rdb_rdata", rsp_rdata, 32'h000000AA);
    tick();
    chk("rdb_hold", {rsp_rdata[30:0], rsp_valid}, {31'h000000AA, 1'b1});
    take_rsp();

    // Half read at 2, zero wait.
    send(1'b0, 32'h00000002, 2'd1, 32'h0);
    HRDATA = 32'h12345678;
    tick();
    tick();
    HRDATA = 32'h0;
    tick();
    chk("rdh_rdata", rsp_rdata, 32'h00001234);
    take_rsp();

    // Half write steering.
    send(1'b1, 32'h00000002, 2'd1, 32'h0000BEEF);
    chk("wrh_hsize", 32'(HSIZE), 32'h1);
    tick();
    chk("wrh_hwdata", HWDATA, 32'hBEEFBEEF);
    tick(); tick();
    take_rsp();

    // Byte write steering.
    send(1'b1, 32'h00000001, 2'd0, 32'h0000005A);
    tick();
    chk("wrb_hwdata", HWDATA, 32'h5A5A5A5A);
    tick(); tick();
    take_rsp();

    // Misaligned half: no bus cycle, error after edge 1.
    send(1'b0, 32'h00000001, 2'd1, 32'h0);
    chk("mis_no_nonseq", {30'h0, HTRANS}, 32'h0);
    chk("mis_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("mis_rsp", {29'h0, rsp_valid, rsp_error, HTRANS == 2'b10}, 32'h6);
    take_rsp();

    // Illegal size 3.
    send(1'b0, 32'h00000000, 2'd3, 32'h0);
    tick();
    chk("sz3_rsp", {29'h0, rsp_valid, rsp_error, rsp_timeout}, 32'h6);
    take_rsp();

    // Slave ERROR, two-cycle response.
    send(1'b0, 32'h00000010, 2'd2, 32'h0);
    tick();
    HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hDEADBEEF;
    tick();
    chk("err_hold", {29'h0, rsp_valid, HTRANS}, 32'h0);
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0; HRDATA = 32'h0;
    tick();
    chk("err_rsp", {29'h0, rsp_valid, rsp_error, cmd_ready}, 32'h6);
    chk("err_rdata", rsp_rdata, 32'h0);
    take_rsp();
    chk("err_cmd_ready", 32'(cmd_ready), 32'h1);

    // Watchdog: HREADY stuck low in ADDR.
    HREADY = 1'b0;
    send(1'b0, 32'h00000040, 2'd2, 32'h0);
    stable = 0;
    for (int i = 0; i < 8; i++) begin
      if (HTRANS == 2'b10 && HADDR == 32'h40) stable++;
      if (i < 7) tick();
    end
    chk("to_addr_stable", 32'(stable), 32'd8);
    tick();
    chk("to_htrans_idle", 32'(HTRANS), 32'h0);
    HREADY = 1'b1;
    tick();
    chk("to_rsp", {29'h0, rsp_valid, rsp_error, rsp_timeout}, 32'h7);
    take_rsp();

    // Async reset during DATA with a pending response.
    send(1'b1, 32'h00000080, 2'd2, 32'hCAFEF00D);
    tick();
    HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge HCLK); HRESETn = 1'b1; HREADY = 1'b1;
    tick();
    send(1'b0, 32'h00000100, 2'd2, 32'h0);
    HRDATA = 32'h11223344;
    tick();
    tick();
    HRDATA = 32'h0;
    tick();
    chk("post_rst_rsp", rsp_rdata, 32'h11223344);
    take_rsp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
